// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bnn_pkg
//  Brief    : Shared UART receiver types and default bit timing.
//  Revision : 1.0
// ============================================================================
package bnn_pkg;

    localparam int unsigned c_CLKS_PER_BIT_DEFAULT = 87;  // 10 MHz / 115200

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_if
//  Brief    : Byte handshake and status bundle between uart_rx and its consumer.
//  Revision : 1.0
// ============================================================================
interface uart_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       rx_busy;
    logic       frame_err;
    logic       overrun_err;

    modport master (
        output rx_data, rx_valid, rx_busy, frame_err, overrun_err,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, rx_busy, frame_err, overrun_err,
        output rx_ready
    );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Brief    : Single-bit two-flop synchronizer with configurable reset value.
//  Revision : 1.0
// ============================================================================
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Brief    : 8N1 UART receiver with one-byte holding register and error pulses.
//  Revision : 1.0
// ============================================================================
module uart_rx
    import bnn_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = c_CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    uart_rx_if.master  rx_bus
);

    localparam logic [15:0] c_HALF_M1 = 16'(CLKS_PER_BIT / 2) - 16'd1;
    localparam logic [15:0] c_BIT_M1  = 16'(CLKS_PER_BIT) - 16'd1;

    logic           rx_s;
    logic           rx_prev_q;
    uart_rx_state_e state_q,     state_d;
    logic [15:0]    cnt_q,       cnt_d;
    logic [2:0]     bit_idx_q,   bit_idx_d;
    logic [7:0]     shift_q,     shift_d;
    logic           frame_ok_q,  frame_ok_d;
    logic           frame_err_q, frame_err_d;
    logic [7:0]     data_q,      data_d;
    logic           valid_q,     valid_d;
    logic           overrun_q,   overrun_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_prev_q   <= 1'b1;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_prev_q   <= rx_s;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit
                if (cnt_q == c_HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (cnt_q == c_BIT_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (cnt_q == c_BIT_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d    = ST_IDLE;
                        frame_ok_d = 1'b1;
                    end else begin
                        state_d     = ST_WAIT_IDLE;
                        frame_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // A good frame is committed one cycle after the stop sample; a same-cycle
    // handshake frees the holding register for the new byte.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && rx_bus.rx_ready) begin
            valid_d = 1'b0;
        end
        if (frame_ok_q) begin
            if (!valid_q || rx_bus.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    assign rx_bus.rx_data     = data_q;
    assign rx_bus.rx_valid    = valid_q;
    assign rx_bus.rx_busy     = (state_q != ST_IDLE);
    assign rx_bus.frame_err   = frame_err_q;
    assign rx_bus.overrun_err = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Brief    : Scoreboard bench for uart_rx at 8 clocks per bit.
//  Revision : 1.0
// ============================================================================
module tb_uart_rx;

    localparam int unsigned c_CPB = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;

    uart_rx_if u_if ();

    uart_rx #(
        .CLKS_PER_BIT (c_CPB)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .rx_bus (u_if)
    );

    always #5 clk = ~clk;

    int         n_vec    = 0;
    int         n_err    = 0;
    int         cyc      = 0;
    int         n_ferr   = 0;
    int         n_oerr   = 0;
    int         n_pop    = 0;
    int         rise_cyc = 0;
    int         fall_cyc = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Output monitor: pulse counting and scoreboard pops on handshakes
    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.frame_err)   n_ferr++;
            if (u_if.overrun_err) n_oerr++;
            if (u_if.rx_valid && !valid_prev) rise_cyc = cyc;
            if (u_if.rx_valid && u_if.rx_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    chk("spurious_byte", {24'd0, u_if.rx_data}, 32'h100);
                end else begin
                    chk("rx_data", {24'd0, u_if.rx_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
        valid_prev = u_if.rx_valid;
    end

    // Caller sits 2 time units after a rising edge on entry and exit
    task automatic drive_bit(input logic b, input int cycles);
        rx = b;
        repeat (cycles) @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        fall_cyc = cyc;
        drive_bit(1'b0, c_CPB);
        for (int i = 0; i < 8; i++) drive_bit(d[i], c_CPB);
        drive_bit(stop, c_CPB);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ferr0, oerr0, pop0;
        u_if.rx_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("rst_valid",   u_if.rx_valid,    0);
        chk("rst_data",    u_if.rx_data,     0);
        chk("rst_busy",    u_if.rx_busy,     0);
        chk("rst_ferr",    u_if.frame_err,   0);
        chk("rst_overrun", u_if.overrun_err, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;
        drive_bit(1'b1, 4);

        // 0xA5 and start-to-valid latency
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, 12);
        wait_drain("a5_drain", 50);
        chk("a5_latency", rise_cyc - fall_cyc - 1, 79);
        chk("a5_valid_low", u_if.rx_valid, 0);
        chk("a5_ferr", n_ferr, 0);

        // Short glitch is a false start
        pop0 = n_pop;
        drive_bit(1'b0, 2);
        drive_bit(1'b1, 3);
        chk("glitch_busy", u_if.rx_busy, 1);
        drive_bit(1'b1, 25);
        chk("glitch_idle", u_if.rx_busy, 0);
        chk("glitch_nopop", n_pop, pop0);
        chk("glitch_ferr", n_ferr, 0);

        // Bad stop bit, line held low, then recovery
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b0, 40);
        chk("ferr_pulses", n_ferr, 1);
        chk("ferr_wait_busy", u_if.rx_busy, 1);
        chk("ferr_no_valid", u_if.rx_valid, 0);
        drive_bit(1'b1, 16);
        chk("ferr_back_idle", u_if.rx_busy, 0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1);
        drive_bit(1'b1, 12);
        wait_drain("x81_drain", 50);
        chk("x81_ferr", n_ferr, 1);

        // Overrun with consumer stalled
        u_if.rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        drive_bit(1'b1, 12);
        chk("ovr_valid", u_if.rx_valid, 1);
        chk("ovr_data", u_if.rx_data, 32'h11);
        chk("ovr_pulses", n_oerr, 1);
        u_if.rx_ready = 1'b1;
        wait_drain("ovr_drain", 20);
        drive_bit(1'b1, 2);
        chk("ovr_valid_clr", u_if.rx_valid, 0);
        chk("ovr_data_kept", u_if.rx_data, 32'h11);

        // Reset during data bit 4 of 0xFF
        drive_bit(1'b0, c_CPB);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, c_CPB);
        drive_bit(1'b1, 4);
        chk("mid_busy", u_if.rx_busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy",  u_if.rx_busy,     0);
        chk("mid_rst_data",  u_if.rx_data,     0);
        chk("mid_rst_valid", u_if.rx_valid,    0);
        chk("mid_rst_ferr",  u_if.frame_err,   0);
        chk("mid_rst_ovr",   u_if.overrun_err, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        drive_bit(1'b1, 16);
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1);
        drive_bit(1'b1, 12);
        wait_drain("x5a_drain", 50);

        // Back-to-back frames, no idle gap
        ferr0 = n_ferr;
        oerr0 = n_oerr;
        pop0  = n_pop;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h55);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
        drive_bit(1'b1, 12);
        wait_drain("b2b_drain", 50);
        chk("b2b_pops", n_pop - pop0, 3);
        chk("b2b_ferr", n_ferr, ferr0);
        chk("b2b_ovr",  n_oerr, oerr0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, clk cycles per UART bit (10 MHz / 115200); legal range 8..65535.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 rx  input  1  serial line from the pin, asynchronous, idle high.
REQ-005 rx_data  output  8  last accepted byte; stable while rx_valid=1.
REQ-006 rx_valid  output  1  byte available in the holding register.
REQ-007 rx_ready  input  1  consumer (bnn_controller) accepts the byte when rx_valid & rx_ready at a clk edge.
REQ-008 rx_busy  output  1  high in every state except IDLE.
REQ-009 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 overrun_err  output  1  one-cycle pulse when a completed byte is dropped because the holding register is full.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (reset value 1) before use; rx_s denotes the synchronized line.
REQ-012 FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
REQ-013 IDLE: on rx_s falling (previous 1, current 0) -> START, bit counter cleared.
REQ-014 HALF = CLKS_PER_BIT/2 (integer division); START samples rx_s when the counter reaches HALF-1.
REQ-015 START sample 1 = false start -> IDLE, no error flag; sample 0 -> DATA, counter and bit index cleared.
REQ-016 DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register; after bit 7 -> STOP.
REQ-017 STOP: sample after CLKS_PER_BIT cycles; 1 = good frame -> IDLE; 0 = frame error -> WAIT_IDLE.
REQ-018 WAIT_IDLE: remain until rx_s=1 (break/line-low tolerance), then -> IDLE; no new start is detected meanwhile.
REQ-019 Good frame with rx_valid=0, or rx_valid=1 & rx_ready=1 in the same cycle: load rx_data, rx_valid=1 the following cycle.
REQ-020 Good frame with rx_valid=1 & rx_ready=0: byte dropped, overrun_err pulses, rx_data/rx_valid unchanged.
REQ-021 Frame error: byte discarded, frame_err pulses, holding register untouched.
REQ-022 rx_valid clears the cycle after a handshake unless REQ-019 reloads it in that same cycle.
REQ-023 Latency: from the first clk edge seeing rx=0, rx_valid rises after exactly 2 + HALF + 9*CLKS_PER_BIT + 1 clk cycles.
REQ-024 Counter is 16 bits and SHALL NOT wrap within a bit period for any legal CLKS_PER_BIT.
REQ-025 rx_ready has no effect while rx_valid=0; rx_data value while rx_valid=0 is don't-care.

Reset
REQ-026 rst asserted SHALL immediately force: state IDLE, synchronizer flops 1, counters 0, shift register 0, rx_data 0, rx_valid 0, frame_err 0, overrun_err 0, rx_busy 0.
REQ-027 rst mid-frame abandons the frame; after release, a new start is detected only after rx_s has been seen high and then falls.

Structure
REQ-028 Shared package bnn_pkg holds the FSM state enum typedef and the default CLKS_PER_BIT constant.
REQ-029 Synchronizer is a separate sub-module sync_2ff (1-bit, async active-high reset, reset value parameterized).
REQ-030 uart_rx sits between the rx pin and bnn_controller; it contains no transmit logic.

Verification (CLKS_PER_BIT=8, HALF=4)
REQ-031 Send 0xA5, 8N1, rx_ready=1 -> rx_valid high one cycle, rx_data=0xA5, rising 79 cycles after rx falls.
REQ-032 Glitch rx low for 2 cycles -> returns to IDLE, no rx_valid, no frame_err.
REQ-033 Send 0x3C with stop bit 0, line held low 40 cycles -> frame_err one pulse, FSM holds in WAIT_IDLE until rx high, then 0x81 is received correctly.
REQ-034 rx_ready=0, send 0x11 then 0x22 -> rx_data stays 0x11, overrun_err one pulse at the end of the second frame; rx_ready=1 -> 0x11 consumed.
REQ-035 Assert rst during DATA bit 4 of 0xFF -> all outputs 0 immediately; next frame 0x5A received correctly.
REQ-036 Back-to-back 0x00, 0xFF, 0x55 with no idle gap, rx_ready=1 -> three valid bytes in order, no errors.
